// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin coding, coin values, dispenser FSM states, prices.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_10 = 2'b00,
    COIN_20 = 2'b01,
    COIN_50 = 2'b10
  } coin_code_e;

  localparam int unsigned COIN_10_VAL = 10;
  localparam int unsigned COIN_20_VAL = 20;
  localparam int unsigned COIN_50_VAL = 50;

  localparam int unsigned PRICE_WATER = 30;
  localparam int unsigned PRICE_COLA  = 60;
  localparam int unsigned PRICE_JUICE = 80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PICK = 2'b01,
    ST_EMIT = 2'b10,
    ST_DONE = 2'b11
  } disp_state_e;

  // Cent value of a coin code; the unused code maps to 0.
  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_10: coin_value = COIN_10_VAL;
      COIN_20: coin_value = COIN_20_VAL;
      COIN_50: coin_value = COIN_50_VAL;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_stock.sv
// Saturating stock counter for one coin denomination.
// With CHANGE_LOW_STOCK_EN defined, low_o is a registered (count < LOW_THRESH) flag;
// otherwise low_o is tied low and no comparator is built.
module coin_stock #(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned INIT       = 8,
  parameter int unsigned LOW_THRESH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic empty_o,
  output logic low_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);

  // Reject parameter sets the counter cannot represent.
  if ((INIT > (1 << CNT_W) - 1) || (LOW_THRESH > (1 << CNT_W))) begin : g_bad_param
    $error("coin_stock: INIT or LOW_THRESH out of range for CNT_W");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q;

  // Next count: simultaneous inc and dec cancel; saturate at both ends.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count and empty flag registers; empty tracks the new count directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= CNT_INIT;
      empty_q <= (CNT_INIT == '0);
    end else begin
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  assign empty_o = empty_q;

`ifdef CHANGE_LOW_STOCK_EN
  logic low_q;

  // Low-stock flag follows the count one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      low_q <= (INIT < LOW_THRESH);
    end else begin
      low_q <= ({1'b0, count_q} < (CNT_W+1)'(LOW_THRESH));
    end
  end

  assign low_o = low_q;
`else
  assign low_o = 1'b0;
`endif

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a cent amount as 50c/20c/10c coins (greedy, stock-limited)
// over a valid/ack hopper handshake and reports any unpaid shortfall.
// Optional macro CHANGE_LOW_STOCK_EN enables the per-denomination low_stock flags.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W      = 8,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned INIT_STOCK = 8,
  parameter int unsigned LOW_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_code,
  input  logic             coin_ack,
  input  logic             refill,
  input  logic [1:0]       refill_code,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] shortfall,
  output logic [2:0]       low_stock
);

  localparam int unsigned NUM_DENOM = 3;

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       code_q, code_d;
  logic             short_q, short_d;
  logic [AMT_W-1:0] sf_q, sf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [NUM_DENOM-1:0] stock_inc, stock_dec, stock_empty, stock_low;

  // Stock update strobes: refills from the loader, decrements on an acked coin.
  always_comb begin
    stock_inc = '0;
    stock_dec = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      stock_inc[i] = refill && (refill_code == 2'(i));
      stock_dec[i] = (state_q == ST_EMIT) && coin_ack && (code_q == 2'(i));
    end
  end

  coin_stock #(.CNT_W(CNT_W), .INIT(INIT_STOCK), .LOW_THRESH(LOW_THRESH)) u_stock_10 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stock_inc[0]),
    .dec_i   (stock_dec[0]),
    .empty_o (stock_empty[0]),
    .low_o   (stock_low[0])
  );

  coin_stock #(.CNT_W(CNT_W), .INIT(INIT_STOCK), .LOW_THRESH(LOW_THRESH)) u_stock_20 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stock_inc[1]),
    .dec_i   (stock_dec[1]),
    .empty_o (stock_empty[1]),
    .low_o   (stock_low[1])
  );

  coin_stock #(.CNT_W(CNT_W), .INIT(INIT_STOCK), .LOW_THRESH(LOW_THRESH)) u_stock_50 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stock_inc[2]),
    .dec_i   (stock_dec[2]),
    .empty_o (stock_empty[2]),
    .low_o   (stock_low[2])
  );

  // Next-state and next-output logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    code_d  = code_q;
    short_d = short_q;
    sf_d    = sf_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          rem_d   = req_amount;
          short_d = 1'b0;
          sf_d    = '0;
          state_d = ST_PICK;
        end
      end
      ST_PICK: begin
        if ((rem_q >= AMT_W'(COIN_50_VAL)) && !stock_empty[2]) begin
          code_d  = COIN_50;
          state_d = ST_EMIT;
        end else if ((rem_q >= AMT_W'(COIN_20_VAL)) && !stock_empty[1]) begin
          code_d  = COIN_20;
          state_d = ST_EMIT;
        end else if ((rem_q >= AMT_W'(COIN_10_VAL)) && !stock_empty[0]) begin
          code_d  = COIN_10;
          state_d = ST_EMIT;
        end else begin
          short_d = (rem_q != '0);
          sf_d    = rem_q;
          state_d = ST_DONE;
        end
      end
      ST_EMIT: begin
        if (coin_ack) begin
          rem_d   = rem_q - AMT_W'(coin_value(code_q));
          state_d = ST_PICK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_EMIT);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any payout in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      code_q  <= 2'b00;
      short_q <= 1'b0;
      sf_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
      short_q <= short_d;
      sf_q    <= sf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign coin_valid = valid_q;
  assign coin_code  = code_q;
  assign done       = done_q;
  assign short      = short_q;
  assign shortfall  = sf_q;
  assign low_stock  = {stock_low[2], stock_low[1], stock_low[0]};

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized requests
// and refills compared against a greedy payout model.
module tb_change_dispenser;

  localparam int unsigned AMT_W      = 8;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned INIT_STOCK = 8;
  localparam int unsigned LOW_THRESH = 2;
  localparam int          STOCK_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             coin_valid;
  logic [1:0]       coin_code;
  logic             coin_ack = 1'b0;
  logic             refill = 1'b0;
  logic [1:0]       refill_code = 2'b00;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] shortfall;
  logic [2:0]       low_stock;

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_STOCK(INIT_STOCK), .LOW_THRESH(LOW_THRESH)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_ack(coin_ack), .refill(refill), .refill_code(refill_code), .busy(busy),
    .done(done), .short(short), .shortfall(shortfall), .low_stock(low_stock)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mstock[3];       // model stock, index 0=10c 1=20c 2=50c (same as coin code)
  int exp_q[$];        // expected coin codes for the request in flight

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int coin_val(input int d);
    case (d)
      0:       return 10;
      1:       return 20;
      default: return 50;
    endcase
  endfunction

  function automatic int dut_stock(input int d);
    case (d)
      0:       return int'(dut.u_stock_10.count_q);
      1:       return int'(dut.u_stock_20.count_q);
      default: return int'(dut.u_stock_50.count_q);
    endcase
  endfunction

  function automatic void model_refill(input int d);
    if (d < 3 && mstock[d] < STOCK_MAX) mstock[d]++;
  endfunction

  // Greedy payout: repeatedly take the largest affordable coin still in stock.
  function automatic int model_pay(input int amt);
    int rem;
    int pick;
    rem = amt;
    exp_q.delete();
    forever begin
      pick = -1;
      for (int d = 2; d >= 0; d--)
        if (pick < 0 && coin_val(d) <= rem && mstock[d] > 0) pick = d;
      if (pick < 0) break;
      exp_q.push_back(pick);
      mstock[pick]--;
      rem -= coin_val(pick);
    end
    return rem;
  endfunction

  task automatic check_stocks(input string tag);
    int exp_low;
    @(negedge clk);
    @(negedge clk);
    exp_low = 0;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_stock%0dc", tag, coin_val(d)), dut_stock(d), mstock[d]);
`ifdef CHANGE_LOW_STOCK_EN
      if (mstock[d] < int'(LOW_THRESH)) exp_low |= (1 << d);
`endif
    end
    check_eq({tag, "_low_stock"}, int'(low_stock), exp_low);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    req_valid = 1'b0;
    coin_ack = 1'b0;
    refill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) mstock[d] = INIT_STOCK;
  endtask

  // One request; ack_dly<0 means random 0..3 cycle ack delay.
  task automatic run_req(input int amt, input int ack_dly, input bit refill_on_ack);
    int  sf, exp_n, n_got, gap, wait_left, cur_code, cyc, exp_code;
    bit  prev_valid, done_seen, first_ack;
    sf = model_pay(amt);
    exp_n = exp_q.size();
    @(negedge clk);
    check_eq("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_amount = AMT_W'(amt);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("busy_after_accept", int'(busy), 1);
    gap = 1; n_got = 0; wait_left = 0; cur_code = 0; cyc = 0;
    prev_valid = 1'b0; done_seen = 1'b0; first_ack = 1'b1;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      gap++;
      coin_ack = 1'b0;
      refill = 1'b0;
      if (done) begin
        check_eq("done_latency", gap, 2);
        check_eq("done_coin_valid", int'(coin_valid), 0);
        check_eq("coin_count", n_got, exp_n);
        check_eq("short", int'(short), int'(sf != 0));
        check_eq("shortfall", int'(shortfall), sf);
        done_seen = 1'b1;
      end else if (coin_valid) begin
        if (!prev_valid) begin
          check_eq("coin_latency", gap, 2);
          n_got++;
          exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          check_eq("coin_code", int'(coin_code), exp_code);
          cur_code = int'(coin_code);
          wait_left = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
        end else begin
          check_eq("coin_code_stable", int'(coin_code), cur_code);
        end
        if (wait_left == 0) begin
          coin_ack = 1'b1;
          gap = 0;
          if (refill_on_ack && first_ack) begin
            refill = 1'b1;
            refill_code = coin_code;
            model_refill(int'(coin_code));
            first_ack = 1'b0;
          end
        end else begin
          wait_left--;
        end
      end
      prev_valid = coin_valid;
    end
    check_eq("done_seen", int'(done_seen), 1);
    @(negedge clk);
    coin_ack = 1'b0;
    refill = 1'b0;
    check_eq("ready_after_done", int'(req_ready), 1);
  endtask

  initial begin
    int s50, amt, nref, rc;
    bit saw_done;

    // Reset values
    reset_dut();
    @(negedge clk);
    check_eq("rst_req_ready", int'(req_ready), 1);
    check_eq("rst_coin_valid", int'(coin_valid), 0);
    check_eq("rst_coin_code", int'(coin_code), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_short", int'(short), 0);
    check_eq("rst_shortfall", int'(shortfall), 0);
    check_stocks("rst");

    // 30c -> 20c,10c with immediate acks
    run_req(30, 0, 1'b0);
    check_eq("after30_stock20c", dut_stock(1), 7);
    check_eq("after30_stock10c", dut_stock(0), 7);
    check_stocks("after30");

    // 80c -> 50c,20c,10c; 0c -> no coins; 15c -> 10c with 5c shortfall
    run_req(80, 0, 1'b0);
    run_req(0, -1, 1'b0);
    run_req(15, -1, 1'b0);
    check_eq("req15_shortfall", int'(shortfall), 5);
    check_stocks("directed");

    // Drain 10c stock, then 60c pays 50c only with 10c shortfall
    while (mstock[0] > 0) run_req(10, -1, 1'b0);
    run_req(60, -1, 1'b0);
    check_eq("req60_short", int'(short), 1);
    check_eq("req60_shortfall", int'(shortfall), 10);
    check_stocks("drained");

    // Ack held off 20 cycles; refill of 50c on the same cycle as the 50c ack
    s50 = mstock[2];
    run_req(50, 20, 1'b1);
    check_stocks("hold_refill");
    check_eq("refill_ack_50c_unchanged", dut_stock(2), s50);

    // Reset in the middle of EMIT
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = AMT_W'(30);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_coin_valid", int'(coin_valid), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) mstock[d] = INIT_STOCK;
    check_eq("midrst_coin_valid", int'(coin_valid), 0);
    check_eq("midrst_req_ready", int'(req_ready), 1);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_shortfall", int'(shortfall), 0);
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || coin_valid) saw_done = 1'b1;
    end
    check_eq("midrst_no_done_or_coin", int'(saw_done), 0);
    check_stocks("midrst");

    // Randomized requests with idle-time refills and stray acks
    for (int it = 0; it < 40; it++) begin
      nref = $urandom_range(0, 5);
      for (int r = 0; r < nref; r++) begin
        @(negedge clk);
        rc = $urandom_range(0, 3);
        refill = 1'b1;
        refill_code = 2'(rc);
        coin_ack = 1'($urandom_range(0, 1));
        model_refill(rc);
      end
      @(negedge clk);
      refill = 1'b0;
      coin_ack = 1'b0;
      amt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 25)) * 10
                                        : int'($urandom_range(0, 255));
      run_req(amt, -1, 1'b0);
      check_stocks($sformatf("rand%0d", it));
    end

    // Saturate 50c stock with back-to-back refills
    for (int r = 0; r < 70; r++) begin
      @(negedge clk);
      refill = 1'b1;
      refill_code = 2'b10;
      model_refill(2);
    end
    @(negedge clk);
    refill = 1'b0;
    check_stocks("saturate");
    check_eq("sat_50c_max", dut_stock(2), STOCK_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
